// File: rtl/f2s_intr_pkg.sv
// Shared state encoding and counter sizing for the fast-to-slow interrupt pulse shaper.
// No logic and no latency; imported by the lane and the top level.
package f2s_intr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } lane_state_e;

    // The down-counter only has to hold max(HIGH,LOW)-1, but it must be at least one bit wide.
    function automatic int cnt_width(input int high_cycles, input int low_cycles);
        int m;
        m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/f2s_intr_pulse_shaper_if.sv
// Interrupt bundle between the raw fast-domain sources and the pulse shaper.
// Plain wires; the shaper never stalls its source (no ready), excess edges are counted.
interface f2s_intr_pulse_shaper_if #(
    parameter int INTR_WIDTH = 1
);
    logic [INTR_WIDTH-1:0] fast_intr;
    logic [INTR_WIDTH-1:0] ovf_clr;
    logic [INTR_WIDTH-1:0] shaped_intr;
    logic [INTR_WIDTH-1:0] busy;
    logic [INTR_WIDTH-1:0] intr_overflow;

    modport master (
        output fast_intr,
        output ovf_clr,
        input  shaped_intr,
        input  busy,
        input  intr_overflow
    );

    modport slave (
        input  fast_intr,
        input  ovf_clr,
        output shaped_intr,
        output busy,
        output intr_overflow
    );
endinterface

// File: rtl/f2s_intr_shaper_lane.sv
// One interrupt lane: edge detect, HIGH/GAP pulse FSM and saturating pending-edge queue.
// Edge in cycle N drives shaped_intr high N+1..N+HIGH_CYCLES; no backpressure, overflow is sticky.
module f2s_intr_shaper_lane
    import f2s_intr_pkg::*;
#(
    parameter int HIGH_CYCLES = 8,
    parameter int LOW_CYCLES  = 8,
    parameter int PEND_WIDTH  = 4
) (
    input  logic fast_clk,
    input  logic fast_rst,
    input  logic fast_intr,
    input  logic ovf_clr,
    output logic shaped_intr,
    output logic busy,
    output logic intr_overflow
);
    localparam int                    CNT_W     = cnt_width(HIGH_CYCLES, LOW_CYCLES);
    localparam logic [CNT_W-1:0]      HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]      LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX  = '1;

    lane_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PEND_WIDTH-1:0]  pend_q, pend_d;
    logic                   prev_q, prev_d;
    logic                   ovf_q, ovf_d;
    logic                   shaped_q, shaped_d;

    logic edge_det, pend_nz, issue, pend_inc, pend_dec, ovf_set;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        prev_d   = fast_intr;
        issue    = 1'b0;
        edge_det = fast_intr & ~prev_q;
        pend_nz  = (pend_q != '0);

        case (state_q)
            IDLE: issue = edge_det | pend_nz;
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = LOW_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    if (edge_det || pend_nz) issue   = 1'b1;
                    else                     state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            state_d = HIGH;
            cnt_d   = HIGH_LOAD;
        end

        // Backlog is replayed first; the live edge is only consumed when nothing is queued.
        pend_inc = edge_det & ~(issue & ~pend_nz);
        pend_dec = issue & pend_nz;
        ovf_set  = pend_inc & ~pend_dec & (pend_q == PEND_MAX);

        if (pend_inc && !pend_dec && !ovf_set) pend_d = pend_q + PEND_WIDTH'(1);
        else if (pend_dec && !pend_inc)        pend_d = pend_q - PEND_WIDTH'(1);

        if (ovf_set)      ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;

        shaped_d = (state_d == HIGH);
    end

    always_ff @(posedge fast_clk) begin
        if (fast_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= '0;
            prev_q   <= 1'b0;
            ovf_q    <= 1'b0;
            shaped_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            prev_q   <= prev_d;
            ovf_q    <= ovf_d;
            shaped_q <= shaped_d;
        end
    end

    assign shaped_intr   = shaped_q;
    assign busy          = (state_q != IDLE) || (pend_q != '0);
    assign intr_overflow = ovf_q;

endmodule

// File: rtl/f2s_intr_pulse_shaper.sv
// Fast-domain shaper: per-lane pulses of exact high width and minimum low gap for a slow synchronizer.
// One cycle from edge to shaped pulse; never backpressures, queued edges saturate into intr_overflow.
module f2s_intr_pulse_shaper
    import f2s_intr_pkg::*;
#(
    parameter int INTR_WIDTH  = 1,
    parameter int HIGH_CYCLES = 8,
    parameter int LOW_CYCLES  = 8,
    parameter int PEND_WIDTH  = 4
) (
    input  logic                     fast_clk,
    input  logic                     fast_rst,
    f2s_intr_pulse_shaper_if.slave   intr_if
);
    logic [INTR_WIDTH-1:0] shaped_vec;
    logic [INTR_WIDTH-1:0] busy_vec;
    logic [INTR_WIDTH-1:0] ovf_vec;

    for (genvar g = 0; g < INTR_WIDTH; g++) begin : g_lane
        f2s_intr_shaper_lane #(
            .HIGH_CYCLES (HIGH_CYCLES),
            .LOW_CYCLES  (LOW_CYCLES),
            .PEND_WIDTH  (PEND_WIDTH)
        ) u_lane (
            .fast_clk      (fast_clk),
            .fast_rst      (fast_rst),
            .fast_intr     (intr_if.fast_intr[g]),
            .ovf_clr       (intr_if.ovf_clr[g]),
            .shaped_intr   (shaped_vec[g]),
            .busy          (busy_vec[g]),
            .intr_overflow (ovf_vec[g])
        );
    end

    assign intr_if.shaped_intr   = shaped_vec;
    assign intr_if.busy          = busy_vec;
    assign intr_if.intr_overflow = ovf_vec;

endmodule

// File: tb/tb_f2s_intr_pulse_shaper.sv
// Randomized scoreboard bench: a timestamp-based lane model predicts each cycle's outputs.
module tb_f2s_intr_pulse_shaper;
    localparam int W     = 2;
    localparam int H     = 4;
    localparam int L     = 3;
    localparam int P     = 2;
    localparam int PMAX  = (1 << P) - 1;
    localparam int NCYC  = 3000;

    typedef struct packed {
        logic [W-1:0] shaped;
        logic [W-1:0] busy;
        logic [W-1:0] ovf;
    } exp_t;

    logic fast_clk = 1'b0;
    logic fast_rst;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];

    f2s_intr_pulse_shaper_if #(.INTR_WIDTH(W)) intr_if ();

    f2s_intr_pulse_shaper #(
        .INTR_WIDTH  (W),
        .HIGH_CYCLES (H),
        .LOW_CYCLES  (L),
        .PEND_WIDTH  (P)
    ) dut (
        .fast_clk (fast_clk),
        .fast_rst (fast_rst),
        .intr_if  (intr_if)
    );

    always #5 fast_clk = ~fast_clk;

    // Model: a lane may issue at cycle c once c >= last_issue + H + L; each issue drives
    // the output high during cycles last_issue+1 .. last_issue+H.
    int last_iss [W];
    bit has_iss  [W];
    int pend     [W];
    bit prev     [W];
    bit ovf      [W];

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            has_iss[i] = 1'b0; last_iss[i] = 0; pend[i] = 0; prev[i] = 1'b0; ovf[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int c, input bit rst, input logic [W-1:0] intr,
                              input logic [W-1:0] clr, output exp_t e);
        e = '0;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < W; i++) begin
            bit ed, can, iss, from_pend, inc, set;
            ed = intr[i] && !prev[i];
            prev[i] = intr[i];
            can = !has_iss[i] || (c >= last_iss[i] + H + L);
            iss = can && (pend[i] > 0 || ed);
            from_pend = iss && pend[i] > 0;
            if (iss) begin
                last_iss[i] = c;
                has_iss[i]  = 1'b1;
            end
            inc = ed && !(iss && !from_pend);
            set = inc && !from_pend && pend[i] == PMAX;
            if (!set) pend[i] = pend[i] + int'(inc) - int'(from_pend);
            if (set)         ovf[i] = 1'b1;
            else if (clr[i]) ovf[i] = 1'b0;
            e.shaped[i] = has_iss[i] && (c + 1 >= last_iss[i] + 1) && (c + 1 <= last_iss[i] + H);
            e.busy[i]   = (has_iss[i] && (c + 1 <= last_iss[i] + H + L)) || pend[i] > 0;
            e.ovf[i]    = ovf[i];
        end
    endtask

    // Monitor: every cycle the DUT presents a full output word; compare it with the oldest prediction.
    initial begin
        exp_t e;
        int mcyc;
        mcyc = 0;
        forever begin
            @(posedge fast_clk);
            #2;
            mcyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (intr_if.shaped_intr !== e.shaped) begin
                    tests_failed++;
                    $display("FAIL shaped_intr t=%0d got %b exp %b", mcyc, intr_if.shaped_intr, e.shaped);
                end
                tests_run++;
                if (intr_if.busy !== e.busy) begin
                    tests_failed++;
                    $display("FAIL busy t=%0d got %b exp %b", mcyc, intr_if.busy, e.busy);
                end
                tests_run++;
                if (intr_if.intr_overflow !== e.ovf) begin
                    tests_failed++;
                    $display("FAIL intr_overflow t=%0d got %b exp %b", mcyc, intr_if.intr_overflow, e.ovf);
                end
            end
        end
    end

    // Driver: inputs change on the falling edge, the matching prediction is queued at once.
    initial begin
        exp_t          e;
        logic [W-1:0]  intr_v, clr_v;
        bit            rst_v;
        int            phase;
        fast_rst          = 1'b1;
        intr_if.fast_intr = '0;
        intr_if.ovf_clr   = '0;
        model_reset();
        intr_v = '0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge fast_clk);
            phase = (c / 300) % 3;
            rst_v = (c < 3) || ($urandom_range(0, 249) == 0);
            clr_v = '0;
            for (int i = 0; i < W; i++) begin
                if (c < 60) begin
                    intr_v[i] = (c == 10 + i) || (c == 30 && i == 0) || (c == 32 && i == 0)
                                || (c == 34 && i == 0);
                end else if (phase == 0) begin
                    intr_v[i] = ($urandom_range(0, 11) == 0);
                end else if (phase == 1) begin
                    intr_v[i] = 1'($urandom_range(0, 1));
                end else if ($urandom_range(0, 39) == 0) begin
                    intr_v[i] = ~intr_v[i];
                end
                clr_v[i] = ($urandom_range(0, 29) == 0);
            end
            fast_rst          = rst_v;
            intr_if.fast_intr = intr_v;
            intr_if.ovf_clr   = clr_v;
            model_step(c, rst_v, intr_v, clr_v, e);
            exp_q.push_back(e);
        end
        @(negedge fast_clk);
        fast_rst = 1'b0;
        intr_if.fast_intr = '0;
        intr_if.ovf_clr   = '0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge fast_clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
